sram_like_slave: RTL and testbench

Responder end of the core's sram-like request/response interface (req/wr/wstrb/size/addr/wdata → addr_ok/data_ok/rdata). It lets the instruction port or data port of the core talk straight to a synchronous single-port RAM, with no AXI bridge in between. Responses come back in order, after a fixed and configurable latency, and the number of outstanding requests is bounded. One instance serves one port; the top level instantiates two, one for inst and one for data.

---
 rtl/sram_like_slave.sv | 93 +++++++++
 tb/tb_sram_like_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_slave.sv
// Responder end of the core's sram-like interface, wired directly to a synchronous
// single-port RAM. Responses are in order, after a fixed latency LAT, with at most MAX_OUT outstanding.
module sram_like_slave #(
    parameter int ADDR_W  = 16,
    parameter int LAT     = 3,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [3:0]        wstrb,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             hs;
    logic [LAT:1]     v_q;
    logic [LAT:1]     wr_q;
    logic [31:0]      resp_data;
    logic             unused_bits;

    // size, the byte offset and the aliased upper address bits carry no meaning here
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    always_comb begin
        addr_ok   = req && (cnt < CNT_W'(MAX_OUT));
        hs        = addr_ok;
        ram_en    = hs;
        ram_we    = (hs && wr) ? wstrb : '0;
        ram_addr  = addr[ADDR_W+1:2];
        ram_wdata = wdata;
        data_ok   = v_q[LAT];
        rdata     = (v_q[LAT] && !wr_q[LAT]) ? resp_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (hs && !data_ok) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!hs && data_ok) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Stage 1 is the LSB; every stage advances each cycle with no stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q  <= '0;
            wr_q <= '0;
        end else begin
            v_q  <= (v_q << 1) | LAT'(hs);
            wr_q <= (wr_q << 1) | LAT'(hs && wr);
        end
    end

    generate
        if (LAT == 1) begin : g_direct
            always_comb resp_data = ram_rdata;
        end else begin : g_piped
            logic [31:0] data_q [2:LAT];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned k = 2; k <= LAT; k++) begin
                        data_q[k] <= '0;
                    end
                end else begin
                    data_q[2] <= ram_rdata;
                    for (int unsigned k = 3; k <= LAT; k++) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end

            always_comb resp_data = data_q[LAT];
        end
    endgenerate

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: behavioural RAM, queue-based response model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_sram_like_slave;

    localparam int ADDR_W  = 8;
    localparam int LAT     = 4;
    localparam int MAX_OUT = 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic [3:0]        wstrb = '0;
    logic [1:0]        size = '0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    sram_like_slave #(
        .ADDR_W (ADDR_W),
        .LAT    (LAT),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wr       (wr),
        .wstrb    (wstrb),
        .size     (size),
        .addr     (addr),
        .wdata    (wdata),
        .addr_ok  (addr_ok),
        .data_ok  (data_ok),
        .rdata    (rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Write-first synchronous RAM
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_m;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_m = ram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_m[8*b +: 8] = ram_wdata[8*b +: 8];
            ram[ram_addr] <= ram_m;
            ram_rdata     <= ram_m;
        end
    end

    // Reference model: memory image plus a queue of pending responses with due cycles
    typedef struct {
        longint      due;
        logic [31:0] data;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mem [DEPTH];
    bit          m_acc;
    int          m_w;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            chk("rst_data_ok", 32'(data_ok), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_addr_ok", 32'(addr_ok), 32'(req));
            chk("rst_ram_en", 32'(ram_en), 32'(req));
        end else begin
            m_acc = req && (q.size() < MAX_OUT);
            chk("addr_ok", 32'(addr_ok), 32'(m_acc));
            chk("ram_en", 32'(ram_en), 32'(m_acc));
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("data_ok", 32'(data_ok), 32'd1);
                chk("rdata", rdata, q[0].data);
                void'(q.pop_front());
            end else begin
                chk("data_ok", 32'(data_ok), 32'd0);
            end
            if (m_acc) begin
                m_w = int'((addr >> 2) % DEPTH);
                chk("ram_addr", 32'(ram_addr), 32'(m_w));
                chk("ram_wdata", ram_wdata, wdata);
                chk("ram_we", 32'(ram_we), wr ? 32'(wstrb) : 32'd0);
                if (wr)
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mem[m_w][8*b +: 8] = wdata[8*b +: 8];
                q.push_back('{cyc + LAT, wr ? 32'h0 : mem[m_w]});
            end else begin
                chk("ram_we_idle", 32'(ram_we), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        req = 1'b0;
        wr  = 1'b0;
        repeat (n) tick();
    endtask

    // Hold a request until accepted; leaves the bench at the start of the following cycle
    task automatic issue(bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
        int n = 0;
        req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d; size = 2'($urandom);
        #1;
        while (!addr_ok && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (!addr_ok) chk("issue_timeout", 32'(addr_ok), 32'd1);
        tick();
        req = 1'b0;
        wr  = 1'b0;
    endtask

    // One isolated request with literal expectations on handshake and response timing
    task automatic single(string name, bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                          logic [ADDR_W-1:0] exp_waddr, logic [31:0] exp_rdata);
        req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d;
        #1;
        chk({name, "_addr_ok"}, 32'(addr_ok), 32'd1);
        chk({name, "_ram_addr"}, 32'(ram_addr), 32'(exp_waddr));
        chk({name, "_ram_we"}, 32'(ram_we), w ? 32'(s) : 32'd0);
        tick();
        req = 1'b0;
        wr  = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            #1;
            chk({name, "_data_ok_timing"}, 32'(data_ok), (i == LAT) ? 32'd1 : 32'd0);
            if (i == LAT) chk({name, "_rdata"}, rdata, exp_rdata);
            tick();
        end
    endtask

    logic [9:0] ao;
    logic [9:0] dk;
    int         seen;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = init_word(i);
            mem[i] = init_word(i);
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Two reads in flight, then a reset pulse asserted mid-cycle
        issue(1'b0, 4'h0, 32'h0, 32'h0);
        issue(1'b0, 4'h0, 32'h4, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_data_ok", 32'(data_ok), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_addr_ok", 32'(addr_ok), 32'd0);
        chk("midrst_ram_en", 32'(ram_en), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            #1;
            if (data_ok) seen++;
        end
        chk("flight_discarded", 32'(seen), 32'd0);
        tick();
        req = 1'b1; wr = 1'b0; addr = 32'h8;
        #1;
        chk("post_rst_addr_ok", 32'(addr_ok), 32'd1);
        tick();
        idle(LAT + 2);

        // Preload words 0x10 and 0x11, then directed read and partial write
        issue(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
        issue(1'b1, 4'hF, 32'h44, 32'hAAAA_AAAA);
        idle(LAT + 2);
        single("read40", 1'b0, 4'h0, 32'h40, 32'h0, 8'h10, 32'hDEAD_BEEF);
        single("pwr44", 1'b1, 4'b0011, 32'h44, 32'h1234_5678, 8'h11, 32'h0);
        single("read44", 1'b0, 4'h0, 32'h44, 32'h0, 8'h11, 32'hAAAA_5678);
        idle(LAT + 2);

        // Outstanding limit with req held high for six cycles
        req = 1'b1; wr = 1'b0; addr = 32'h40;
        for (int o = 0; o < 10; o++) begin
            if (o == 6) req = 1'b0;
            #1;
            ao[o] = addr_ok;
            dk[o] = data_ok;
            tick();
        end
        chk("limit_addr_ok", 32'(ao), 32'(10'b00_0010_0011));
        chk("limit_data_ok", 32'(dk), 32'(10'b10_0011_0000));
        idle(LAT + 2);

        // Back-to-back reads, read-after-write on a shared word
        issue(1'b0, 4'h0, 32'h0, 32'h0);
        issue(1'b0, 4'h0, 32'h4, 32'h0);
        issue(1'b0, 4'h0, 32'h8, 32'h0);
        issue(1'b0, 4'h0, 32'hC, 32'h0);
        issue(1'b1, 4'b1100, 32'h10, 32'hCAFE_0000);
        issue(1'b0, 4'h0, 32'h10, 32'h0);
        idle(LAT + 2);

        // Randomized traffic over a few aliased words
        for (int i = 0; i < 400; i++) begin
            req   = ($urandom_range(0, 99) < 60);
            wr    = 1'($urandom);
            wstrb = 4'($urandom);
            size  = 2'($urandom);
            ra    = ($urandom_range(0, 3) << (ADDR_W + 2)) | ($urandom_range(0, 7) << 2)
                    | $urandom_range(0, 3);
            addr  = ra;
            wdata = $urandom;
            tick();
        end
        idle(LAT + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
